// File: rtl/vec_dot_acc.sv
// vec_dot_acc: snapshots two LANES-wide vectors and accumulates their dot product one MAC per clock
module vec_dot_acc #(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LANES*WIDTH-1:0] a_vec,
    input  logic [LANES*WIDTH-1:0] b_vec,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   overflow
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t                 state;
    logic [LANES*WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0]       a_l [LANES];
    logic [WIDTH-1:0]       b_l [LANES];
    logic [WIDTH-1:0]       acc;
    logic [IW-1:0]          idx;
    logic                   ovf;
    logic [2*WIDTH-1:0]     p;
    logic [WIDTH:0]         sum;
    logic                   ovf_n;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign a_l[i] = a_q[i*WIDTH +: WIDTH];
        assign b_l[i] = b_q[i*WIDTH +: WIDTH];
    end
    // current lane product, wrapped accumulate and overflow update
    always_comb begin
        p     = {{WIDTH{1'b0}}, a_l[idx]} * {{WIDTH{1'b0}}, b_l[idx]};
        sum   = {1'b0, acc} + {1'b0, p[WIDTH-1:0]};
        ovf_n = ovf | (|p[2*WIDTH-1:WIDTH]) | sum[WIDTH];
    end
    // control FSM with registered busy/done and held result/overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                MAC: begin
                    acc <= sum[WIDTH-1:0];
                    ovf <= ovf_n;
                    idx <= idx + 1'b1;
                    if (idx == IW'(LANES-1)) begin
                        result   <= sum[WIDTH-1:0];
                        overflow <= ovf_n;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a_vec;
                        b_q   <= b_vec;
                        acc   <= '0;
                        idx   <= '0;
                        ovf   <= 1'b0;
                        state <= MAC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_dot_acc.sv
// tb_vec_dot_acc: table, hand-written corner sequences and random ops against an exact-arithmetic model
module tb_vec_dot_acc;
    logic         clk = 0;
    logic         rst, start;
    logic [127:0] a_vec, b_vec;
    logic         busy, done, overflow;
    logic [31:0]  result;
    int           checks = 0;
    int           errors = 0;

    vec_dot_acc #(.LANES(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a_vec(a_vec), .b_vec(b_vec),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [31:0]  r;
        logic         o;
    } vec_t;
    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // true sum of full products; wraps to 32 bits and overflows when it reaches 2^32
    function automatic logic [32:0] model(input logic [127:0] a, input logic [127:0] b);
        logic [67:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s += 68'(a[i*32 +: 32]) * 68'(b[i*32 +: 32]);
        return {s[67:32] != 0, s[31:0]};
    endfunction

    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          input logic [31:0] er, input logic eo, input string name);
        a_vec = a;
        b_vec = b;
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 4; c++) begin
            chk({name, "_busy"}, {31'd0, busy}, 1);
            chk({name, "_nodone"}, {31'd0, done}, 0);
            tick();
        end
        chk({name, "_done"}, {31'd0, done}, 1);
        chk({name, "_idle"}, {31'd0, busy}, 0);
        chk({name, "_result"}, result, er);
        chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        tick();
        chk({name, "_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        logic [127:0] ra, rb;
        logic [32:0]  m;
        tbl[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 32'd70, 1'b0};
        tbl[1] = '{{96'd0, 32'h0001_0000}, {96'd0, 32'h0001_0000}, 32'd0, 1'b1};
        tbl[2] = '{{96'd0, 32'd2}, {96'd0, 32'd3}, 32'd6, 1'b0};
        tbl[3] = '{{64'd0, 32'd1, 32'hFFFF_FFFF}, {64'd0, 32'd1, 32'd1}, 32'd0, 1'b1};
        tbl[4] = '{{4{32'd1}}, {4{32'd1}}, 32'd4, 1'b0};
        rst = 1; start = 0; a_vec = '0; b_vec = '0;
        tick(); tick();
        rst = 0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        for (int i = 0; i < 5; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o, $sformatf("tbl%0d", i));

        // input isolation plus ignored start while busy
        a_vec = {4{32'd1}}; b_vec = {4{32'd1}}; start = 1;
        tick(); start = 0;
        tick();
        a_vec = {4{32'd9}}; start = 1;
        tick(); start = 0;
        tick(); tick();
        chk("iso_done", {31'd0, done}, 1);
        chk("iso_result", result, 4);
        dn = 0;
        for (int c = 6; c <= 14; c++) begin tick(); dn += done; end
        chk("iso_one_done", dn, 0);

        // back-to-back with start held
        a_vec = {32'd4, 32'd3, 32'd2, 32'd1}; b_vec = {32'd8, 32'd7, 32'd6, 32'd5}; start = 1;
        for (int c = 0; c < 5; c++) tick();
        chk("b2b_done1", {31'd0, done}, 1);
        chk("b2b_res1", result, 70);
        b_vec = {4{32'd1}};
        tick();
        chk("b2b_nobubble", {31'd0, busy}, 1);
        for (int c = 6; c < 10; c++) tick();
        start = 0;
        chk("b2b_done2", {31'd0, done}, 1);
        chk("b2b_res2", result, 10);
        tick(); tick();

        // reset mid-operation
        start = 1;
        tick(); start = 0;
        tick(); tick();
        rst = 1;
        tick(); rst = 0;
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_result", result, 0);
        chk("mid_ovf", {31'd0, overflow}, 0);
        dn = 0;
        for (int c = 4; c <= 10; c++) begin dn += done; dn += busy; tick(); end
        chk("mid_no_done", dn, 0);

        // reset beats start
        rst = 1; start = 1;
        tick(); rst = 0; start = 0;
        chk("rs_busy", {31'd0, busy}, 0);
        tick();
        chk("rs_still_idle", {31'd0, busy | done}, 0);

        // random operations, half with small values to keep overflow mixed
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i*32 +: 32] = n[0] ? $urandom : $urandom_range(0, 65535);
                rb[i*32 +: 32] = n[0] ? $urandom : $urandom_range(0, 65535);
            end
            m = model(ra, rb);
            run_op(ra, rb, m[31:0], m[32], $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_dot_acc.md
Name: vec_dot_acc

Overview:
- Downstream consumer of the 8-word multiplier operand memory.
- Its eight stored words are presented as two 4-lane vectors: A = words 0-3 and B = words 4-7.
- On a start request the block snapshots both vectors, then computes the dot product sum(A[i]*B[i]) using one multiply-accumulate per clock.
- It returns a 32-bit result with a one-cycle done pulse and a sticky overflow flag.

Parameters:
- LANES, 4, number of elements per vector; fixes the MAC cycle count.
- WIDTH, 32, bit width of each element and of the result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new dot product.
- a_vec  input  LANES*WIDTH  vector A. Lane i is bits [i*WIDTH +: WIDTH]. Integration: {out4,out3,out2,out1}.
- b_vec  input  LANES*WIDTH  vector B, same lane packing. Integration: {out8,out7,out6,out5}.
- busy  output  1  high while an operation is in progress; start is ignored while high.
- done  output  1  one-cycle pulse marking the cycle in which result is newly valid.
- result  output  WIDTH  final dot product, modulo 2^WIDTH. Held until the next completion or reset.
- overflow  output  1  high if the last completed operation lost bits. Held with result.

Behaviour:
- Reset is synchronous: rst high at a rising edge forces the following, regardless of state or start:
  - state = IDLE
  - busy = 0, done = 0, result = 0, overflow = 0
  - internal accumulator, lane index and snapshot registers cleared
- FSM states:
  - IDLE: busy=0, done=0. If start=1, then at the edge:
    - snapshot a_vec/b_vec into internal registers
    - acc = 0, idx = 0, ovf_int = 0
    - go to MAC
  - MAC: busy=1, done=0. Each edge:
    - p = A[idx]*B[idx], full 2*WIDTH-bit unsigned product
    - acc = acc + p[WIDTH-1:0], modulo 2^WIDTH
    - ovf_int is set if p[2*WIDTH-1:WIDTH] != 0 or the add carries out of bit WIDTH-1
    - idx = idx + 1
    - At the edge processing idx = LANES-1: result <= final acc, overflow <= final ovf_int, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. If start=1, then at the edge:
    - capture again as in IDLE and go to MAC (back-to-back, no bubble)
    - otherwise go to IDLE
- Latency (start high in cycle 0 while in IDLE):
  - capture at the end of cycle 0
  - MAC in cycles 1..LANES
  - done=1 and result valid in cycle LANES+1 (cycle 5 for the default)
- Throughput: one result per LANES+1 cycles.
- Arithmetic: unsigned only. No saturation; result wraps.
- overflow covers only the most recent completed operation. It is not cleared at start, only replaced at completion.
- Input changes after capture have no effect. a_vec/b_vec are sampled only on the capture edge, which covers memory rewrites during MAC.
- start held high continuously gives back-to-back operations, each capturing a_vec/b_vec at its own capture edge.
- Reset mid-operation:
  - the operation is abandoned
  - no done pulse is issued
  - result and overflow are zeroed, not left at the previous value
- Simultaneous rst and start: rst wins; state is IDLE next cycle with nothing captured.
- idx width is ceil(log2(LANES)), minimum 1 bit. LANES must be >= 1.

Test Plan:
- Basic dot product: reset, then A=(1,2,3,4), B=(5,6,7,8), start pulsed in cycle 0 -> busy=1 in cycles 1-4; done=1 only in cycle 5; result=70; overflow=0.
- Product overflow: A=(0x00010000,0,0,0), B=(0x00010000,0,0,0) -> result=0, overflow=1. Follow-up with A=(2,0,0,0), B=(3,0,0,0) -> result=6, overflow=0.
- Accumulator carry: A=(0xFFFFFFFF,1,0,0), B=(1,1,0,0) -> result=0x00000000, overflow=1.
- Input isolation and busy start: start with A=(1,1,1,1), B=(1,1,1,1); in cycle 2 drive A=(9,9,9,9) and pulse start -> result=4, exactly one done pulse, second start ignored.
- Back-to-back: start held high from cycle 0 with A=(1,2,3,4), B=(5,6,7,8); change B to (1,1,1,1) in cycle 5 -> done in cycle 5 with result=70 and in cycle 10 with result=10.
- Reset mid-operation: start in cycle 0, rst=1 in cycle 3 -> in cycle 4 busy=0, result=0, overflow=0; no done pulse through cycle 10.
